// File: rtl/reg_bank_wb.sv
// rtl/reg_bank_wb.sv - 32-entry register file with writeback bypass and stack-pointer reset value
// Entry 0 is hard zero; reads see a same-cycle write (write-first).
module reg_bank_wb #(
  parameter int                DATA_W   = 32,
  parameter int                SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = 32'h0000_03FC,
  parameter bit                REG_READ = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wr_done
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic              wr_done_q, wr_done_d;
  logic              wr_eff;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign wr_eff = wr_en && (wr_addr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_eff) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
    wr_done_d = wr_eff;
  end

  // Bypass so decode sees the value retiring in writeback this cycle.
  always_comb begin
    rs_val = regs_q[rs_addr];
    if (wr_eff && (wr_addr == rs_addr)) rs_val = wr_data;
    if (rs_addr == 5'd0) rs_val = '0;
    rt_val = regs_q[rt_addr];
    if (wr_eff && (wr_addr == rt_addr)) rt_val = wr_data;
    if (rt_addr == 5'd0) rt_val = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      wr_done_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      wr_done_q <= wr_done_d;
    end
  end

  assign wr_done = wr_done_q;

  if (REG_READ) begin : g_reg_read
    logic [DATA_W-1:0] rs_data_q, rt_data_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rs_data_q <= '0;
        rt_data_q <= '0;
      end else begin
        rs_data_q <= rs_val;
        rt_data_q <= rt_val;
      end
    end

    assign rs_data = rs_data_q;
    assign rt_data = rt_data_q;
  end else begin : g_comb_read
    assign rs_data = rs_val;
    assign rt_data = rt_val;
  end

endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- Register file and writeback stage for the RISC datapath.
- Consumes the 5-bit destination register index from the destination-select mux (rd / rt / link register 31), plus writeback data and the write enable.
- Provides two read ports to decode/ALU operand fetch.
- Handles register 0 as constant zero, a stack-pointer reset value, and same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- SP_IDX, 29, index of the stack-pointer register.
- SP_INIT, 32'h0000_03FC, reset value loaded into register SP_IDX.
- REG_READ, 0, 0 = combinational read ports; 1 = registered read ports with 1-cycle latency.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low.
- rs_addr  input  5  read port A register index.
- rt_addr  input  5  read port B register index.
- wr_addr  input  5  write register index, driven by the destination-select mux output.
- wr_data  input  DATA_W  writeback data (ALU result, memory load, or PC+4 for link).
- wr_en  input  1  write enable from control (RegWrite).
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- wr_done  output  1  registered pulse, high for one cycle after an effective write (wr_en=1 and wr_addr!=0).

Behaviour:
- Storage: 32 entries of DATA_W bits.

Reset (rst=0, asynchronous, regardless of clk):
- All entries clear to 0, except entry SP_IDX, which loads SP_INIT.
- wr_done=0.
- If REG_READ=1, the registered rs_data/rt_data clear to 0.
- In REG_READ=0 mode, outputs follow the reset contents combinationally.
- Reset asserted mid-operation discards any write in that cycle. The first write is accepted on the first rising edge after rst returns to 1.

Write:
- On a rising edge with rst=1 and wr_en=1 and wr_addr!=0: entry[wr_addr] <= wr_data.
- A write to index 0 is ignored; entry 0 always reads 0.
- wr_done <= (wr_en && wr_addr!=0) on every edge.

Read, REG_READ=0 (combinational):
- rs_data = 0 if rs_addr==0.
- Else rs_data = wr_data if (wr_en && wr_addr==rs_addr).
- Else rs_data = entry[rs_addr].
- rt_data follows the same rules with rt_addr.
- The bypass gives write-first semantics within a cycle, so decode sees the value retiring in writeback.

Read, REG_READ=1 (registered):
- At each rising edge, rs_data/rt_data register the value the combinational rule above yields at that edge, bypass included.
- Latency is exactly 1 cycle from address to data.

Simultaneous events:
- rs_addr==rt_addr==wr_addr with wr_en=1: both ports return wr_data (0 if the address is 0).
- Bypass is inhibited when wr_en=0 or wr_addr==0.

Other rules:
- Unknown or X addresses are not required to be handled.
- There are no stall or back-pressure inputs; a write completes in one cycle.

Width:
- wr_data is stored unmodified. No sign or zero extension happens in this block.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then read every index → SP_IDX returns 32'h0000_03FC, all others return 0, wr_done=0. Assert rst=0 between edges → contents clear immediately.
- Basic write/read: write 32'hDEAD_BEEF to r8, then 32'h1234_5678 to r31 (link) → next cycle rs_addr=8 gives DEAD_BEEF, rt_addr=31 gives 1234_5678, wr_done pulses once per write.
- r0 protection: wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF → rs_addr=0 reads 0, no bypass, wr_done=0.
- Bypass: same cycle wr_en=1, wr_addr=rs_addr=rt_addr=5, wr_data=32'hA5A5_A5A5, old r5=0 → both outputs show A5A5_A5A5 combinationally (REG_READ=0). With REG_READ=1, the value appears on the next edge.
- Reset mid-operation: write r9=32'h1 and capture it, then assert rst low coincident with a pending write r9=32'h2 → r9 reads 0, SP reads SP_INIT. After release, a write r9=32'h3 succeeds on the first edge.
- Back-to-back: write r1..r31 on consecutive cycles with data = index*3, then sweep reads → every register holds index*3 except r29, which holds 87 (overwritten), and r0=0.
